seg_display_arbiter: RTL and testbench

//  - Owns the 8-digit hex buffer behind the multiplexed 7-seg (an/d) display.
//  - Shares it between two writers (e.g. switch/button logic, UART decoder) via round-robin

---
 rtl/seg_display_arbiter_if.sv | 33 +++
 rtl/seg_display_arbiter.sv | 138 +++++++++++++
 tb/tb_seg_display_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_display_arbiter_if.sv
// seg_display_arbiter_if
//   Write-request bundle for the two display writers of seg_display_arbiter.
//   Each requester K has:
//     reqK_valid  write pending (requester -> arbiter)
//     reqK_ready  write accepted this cycle (arbiter -> requester)
//     reqK_op     0 = write digit reqK_idx, 1 = shift-insert at digit 0
//     reqK_idx    target digit 0..7 (ignored when op=1)
//     reqK_data   hex value
//   modport master: requester side; modport slave: arbiter side.
interface seg_display_arbiter_if;
    logic       req0_valid;
    logic       req0_ready;
    logic       req0_op;
    logic [2:0] req0_idx;
    logic [3:0] req0_data;
    logic       req1_valid;
    logic       req1_ready;
    logic       req1_op;
    logic [2:0] req1_idx;
    logic [3:0] req1_data;

    modport master (
        output req0_valid, req0_op, req0_idx, req0_data,
        output req1_valid, req1_op, req1_idx, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_idx, req0_data,
        input  req1_valid, req1_op, req1_idx, req1_data,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
//   Owns the 8-digit hex buffer behind a multiplexed 7-seg display. Two writers
//   share it through round-robin valid/ready arbitration; one digit is scanned
//   onto an/d every 2^SCAN_DIV clock cycles.
// Ports
//   clk         system clock
//   rst_n       synchronous, active-low reset
//   clr         one-cycle pulse: zero all digits (blocks writes that cycle)
//   digit_mask  digits to scan (only with SEG_DIGIT_MASK_EN defined)
//   bus         write requests (seg_display_arbiter_if.slave)
//   an          index of the digit currently driven (registered)
//   d           hex value of the digit currently driven (registered)
// Configuration
//   SEG_DIGIT_MASK_EN: adds digit_mask; the scan skips digits whose mask bit
//   is 0, and with an all-zero mask the scan holds and d is forced to 0.
module seg_display_arbiter #(
    parameter int unsigned SCAN_DIV = 18
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
`ifdef SEG_DIGIT_MASK_EN
    input  logic [7:0]                  digit_mask,
`endif
    seg_display_arbiter_if.slave        bus,
    output logic [2:0]                  an,
    output logic [3:0]                  d
);

    typedef enum logic {
        RR_REQ0 = 1'b0,
        RR_REQ1 = 1'b1
    } rr_t;

    rr_t                 rr;
    logic [SCAN_DIV-1:0] presc;
    logic [2:0]          ptr;
    logic [2:0]          next_ptr;
    logic [3:0]          digits [8];

    logic       grant0;
    logic       grant1;
    logic       xfer0;
    logic       xfer1;
    logic       wr_op;
    logic [2:0] wr_idx;
    logic [3:0] wr_data;

    // Ready is combinational so a lone request is accepted in the cycle it
    // appears; the rr pointer only breaks ties.
    always_comb begin
        grant0  = bus.req0_valid && (!bus.req1_valid || rr == RR_REQ0);
        grant1  = bus.req1_valid && (!bus.req0_valid || rr == RR_REQ1);
        xfer0   = rst_n && !clr && grant0;
        xfer1   = rst_n && !clr && grant1;
        wr_op   = bus.req0_op;
        wr_idx  = bus.req0_idx;
        wr_data = bus.req0_data;
        if (xfer1) begin
            wr_op   = bus.req1_op;
            wr_idx  = bus.req1_idx;
            wr_data = bus.req1_data;
        end
    end

    assign bus.req0_ready = xfer0;
    assign bus.req1_ready = xfer1;

`ifdef SEG_DIGIT_MASK_EN
    // First enabled digit after ptr, searching forward with wrap; if none
    // besides (possibly) ptr itself is enabled, the scan stays put.
    always_comb begin
        logic       found;
        logic [2:0] cand;
        next_ptr = ptr;
        found    = 1'b0;
        cand     = ptr;
        for (int unsigned i = 1; i < 8; i++) begin
            cand = ptr + 3'(i);
            if (!found && digit_mask[cand]) begin
                next_ptr = cand;
                found    = 1'b1;
            end
        end
    end
`else
    always_comb begin
        next_ptr = ptr + 3'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr    <= RR_REQ0;
            presc <= '0;
            ptr   <= '0;
            an    <= '0;
            d     <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                digits[3'(i)] <= '0;
            end
        end else begin
            if (clr) begin
                for (int unsigned i = 0; i < 8; i++) begin
                    digits[3'(i)] <= '0;
                end
            end else if (xfer0 || xfer1) begin
                if (wr_op) begin
                    for (int unsigned i = 1; i < 8; i++) begin
                        digits[3'(i)] <= digits[3'(i - 1)];
                    end
                    digits[0] <= wr_data;
                end else begin
                    digits[wr_idx] <= wr_data;
                end
            end

            if (xfer0) begin
                rr <= RR_REQ1;
            end else if (xfer1) begin
                rr <= RR_REQ0;
            end

            presc <= presc + SCAN_DIV'(1);
            if (presc == '1) begin
                ptr <= next_ptr;
            end

            an <= ptr;
`ifdef SEG_DIGIT_MASK_EN
            d  <= (digit_mask == '0) ? '0 : digits[ptr];
`else
            d  <= digits[ptr];
`endif
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter
//   Scoreboard bench for seg_display_arbiter (SCAN_DIV=2). Stimulus pushes the
//   expected grant order and expected (an, d) pairs into queues; a monitor on
//   the falling edge pops and compares them, and also checks the ready rules
//   and the scan stepping every cycle.
module tb_seg_display_arbiter;

    typedef struct {
        logic       op;
        logic [2:0] idx;
        logic [3:0] data;
    } item_t;

    typedef struct {
        logic [2:0] k;
        logic [3:0] v;
    } disp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] an;
    logic [3:0] d;
`ifdef SEG_DIGIT_MASK_EN
    logic [7:0] digit_mask = 8'hFF;
`endif

    seg_display_arbiter_if bus();

    seg_display_arbiter #(.SCAN_DIV(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
`ifdef SEG_DIGIT_MASK_EN
        .digit_mask (digit_mask),
`endif
        .bus        (bus),
        .an         (an),
        .d          (d)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    exp_q [$];
    disp_t disp_q [$];
    item_t q0 [$];
    item_t q1 [$];

    // ---------------- monitor ----------------
    int         cyc = 0;
    int         last_cyc = 0;
    int         gwait = 0;
    int         dwait = 0;
    int         got;
    int         want;
    logic       have_prev = 1'b0;
    logic [2:0] prev_an = '0;
    logic [2:0] step_exp;
    logic       r0;
    logic       r1;

`ifdef SEG_DIGIT_MASK_EN
    function automatic logic [2:0] next_set(input logic [2:0] p, input logic [7:0] m);
        logic [2:0] c;
        next_set = p;
        for (int i = 7; i >= 1; i--) begin
            c = p + 3'(i);
            if (m[c]) next_set = c;
        end
    endfunction
`endif

    always @(negedge clk) begin
        cyc++;
        r0 = bus.req0_ready;
        r1 = bus.req1_ready;

        checks++;
        if ((r0 && r1) || ((r0 || r1) && (!rst_n || clr)) ||
            (r0 && !bus.req0_valid) || (r1 && !bus.req1_valid)) begin
            errors++;
            $display("FAIL ready_rules: got ready0=%0b ready1=%0b (valid0=%0b valid1=%0b rst_n=%0b clr=%0b), required at most one, only with valid, rst_n=1, clr=0",
                     r0, r1, bus.req0_valid, bus.req1_valid, rst_n, clr);
        end

        if (r0 || r1) begin
            gwait = 0;
            got = r1 ? 1 : 0;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_grant: got grant to req%0d, required none", got);
            end else begin
                want = exp_q.pop_front();
                if (got != want) begin
                    errors++;
                    $display("FAIL grant_order: got req%0d, required req%0d", got, want);
                end
            end
        end else if (exp_q.size() != 0) begin
            gwait++;
            if (gwait > 100) begin
                checks++;
                errors++;
                $display("FAIL grant_timeout: %0d expected grants never seen", exp_q.size());
                exp_q.delete();
                gwait = 0;
            end
        end

        if (disp_q.size() != 0) begin
            if (an == disp_q[0].k) begin
                checks++;
                if (d !== disp_q[0].v) begin
                    errors++;
                    $display("FAIL digit%0d: got d=%h, required %h", disp_q[0].k, d, disp_q[0].v);
                end
                void'(disp_q.pop_front());
                dwait = 0;
            end else begin
                dwait++;
                if (dwait > 80) begin
                    checks++;
                    errors++;
                    $display("FAIL digit%0d_timeout: an never reached %0d (an=%0d)", disp_q[0].k, disp_q[0].k, an);
                    void'(disp_q.pop_front());
                    dwait = 0;
                end
            end
        end

        if (!rst_n) begin
            have_prev = 1'b0;
        end else if (an !== prev_an) begin
            if (have_prev) begin
                checks++;
`ifdef SEG_DIGIT_MASK_EN
                step_exp = next_set(prev_an, digit_mask);
                if (an !== step_exp || ((cyc - last_cyc) % 4) != 0) begin
`else
                step_exp = prev_an + 3'd1;
                if (an !== step_exp || (cyc - last_cyc) != 4) begin
`endif
                    errors++;
                    $display("FAIL scan_step: got an %0d->%0d after %0d cycles, required %0d after 4 cycles",
                             prev_an, an, cyc - last_cyc, step_exp);
                end
            end
            have_prev = 1'b1;
            last_cyc  = cyc;
        end
        prev_an = an;
    end

    // ---------------- stimulus helpers ----------------
    task automatic expect_digit(input logic [2:0] k, input logic [3:0] v);
        disp_t e;
        e.k = k;
        e.v = v;
        disp_q.push_back(e);
    endtask

    task automatic drive_heads();
        bus.req0_valid = (q0.size() != 0);
        bus.req1_valid = (q1.size() != 0);
        if (q0.size() != 0) begin
            bus.req0_op   = q0[0].op;
            bus.req0_idx  = q0[0].idx;
            bus.req0_data = q0[0].data;
        end
        if (q1.size() != 0) begin
            bus.req1_op   = q1[0].op;
            bus.req1_idx  = q1[0].idx;
            bus.req1_data = q1[0].data;
        end
    endtask

    // Presents queue heads, retires an item when its ready is seen, holds
    // valid/op/idx/data stable until then. Leaves two edges for d to settle.
    task automatic run_items();
        int budget = 120;
        while ((q0.size() != 0 || q1.size() != 0) && budget > 0) begin
            @(posedge clk); #1;
            clr = 1'b0;
            drive_heads();
            @(negedge clk);
            if (bus.req0_ready) void'(q0.pop_front());
            if (bus.req1_ready) void'(q1.pop_front());
            budget--;
        end
        q0.delete();
        q1.delete();
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || disp_q.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            $display("FAIL drain_timeout: scoreboard queues never emptied");
            $fatal(1);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic push_item(input int who, input logic op, input logic [2:0] idx, input logic [3:0] data);
        item_t it;
        it.op   = op;
        it.idx  = idx;
        it.data = data;
        if (who == 0) q0.push_back(it);
        else          q1.push_back(it);
        exp_q.push_back(who);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bus.req0_valid = 1'b0; bus.req0_op = 1'b0; bus.req0_idx = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_op = 1'b0; bus.req1_idx = '0; bus.req1_data = '0;

        // Reset held 3 cycles with both requesters valid: no ready, an=0, d=0.
        #1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        repeat (3) @(posedge clk);
        expect_digit(3'd0, 4'h0);
        drain();
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst_n = 1'b1;

        // Free scan after release: 1..7 then back to 0, all zero.
        for (int k = 1; k <= 8; k++) expect_digit(3'(k), 4'h0);
        drain();

        // Single write: digit 5 <- A, neighbours stay 0.
        push_item(0, 1'b0, 3'd5, 4'hA);
        run_items();
        expect_digit(3'd5, 4'hA);
        expect_digit(3'd4, 4'h0);
        expect_digit(3'd6, 4'h0);
        drain();

        // Contention right after reset: grants 0,1,0,1; reset wiped digit 5.
        pulse_reset();
        push_item(0, 1'b0, 3'd1, 4'h1);
        push_item(1, 1'b0, 3'd2, 4'h2);
        push_item(0, 1'b0, 3'd3, 4'h3);
        push_item(1, 1'b0, 3'd4, 4'h4);
        run_items();
        expect_digit(3'd1, 4'h1);
        expect_digit(3'd2, 4'h2);
        expect_digit(3'd3, 4'h3);
        expect_digit(3'd4, 4'h4);
        expect_digit(3'd5, 4'h0);
        drain();

        // Shift-insert 1,2,3 from req1 after clr.
        pulse_clr();
        push_item(1, 1'b1, 3'd0, 4'h1);
        push_item(1, 1'b1, 3'd0, 4'h2);
        push_item(1, 1'b1, 3'd0, 4'h3);
        run_items();
        expect_digit(3'd0, 4'h3);
        expect_digit(3'd1, 4'h2);
        expect_digit(3'd2, 4'h1);
        expect_digit(3'd3, 4'h0);
        drain();

        // Nine shifts 1..9: digit 7 ends at 2 (1 fell off), digit 0 at 9.
        pulse_clr();
        for (int v = 1; v <= 9; v++) push_item(1, 1'b1, 3'd0, 4'(v));
        run_items();
        expect_digit(3'd0, 4'h9);
        expect_digit(3'd6, 4'h3);
        expect_digit(3'd7, 4'h2);
        drain();

        // clr in the same cycle req0 appears: blocked, then served next cycle.
        push_item(0, 1'b0, 3'd6, 4'h7);
        @(posedge clk); #1;
        clr = 1'b1;
        drive_heads();
        run_items();
        expect_digit(3'd6, 4'h7);
        expect_digit(3'd7, 4'h0);
        expect_digit(3'd0, 4'h0);
        expect_digit(3'd5, 4'h0);
        drain();

`ifdef SEG_DIGIT_MASK_EN
        // Mask 0010_0101: scan visits 0,2,5,0 only; masked digits still written.
        digit_mask = 8'b0010_0101;
        pulse_reset();
        push_item(0, 1'b0, 3'd0, 4'hC);
        push_item(0, 1'b0, 3'd2, 4'hC);
        push_item(0, 1'b0, 3'd5, 4'hC);
        run_items();
        expect_digit(3'd2, 4'hC);
        expect_digit(3'd5, 4'hC);
        expect_digit(3'd0, 4'hC);
        drain();
        // Empty mask while on digit 0: an frozen, d forced to 0.
        @(posedge clk); #1;
        digit_mask = 8'h00;
        repeat (3) @(posedge clk);
        expect_digit(3'd0, 4'h0);
        drain();
        repeat (40) @(posedge clk);
        expect_digit(3'd0, 4'h0);
        drain();
`endif

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
